genius_jogo_param: RTL and testbench

Parametrised successor of the fixed 4-button, 16-move memory game core. It shows a stored sequence on the LEDs one round at a time, and the player repeats it on the buttons. A per-move timeout applies, and a difficulty input selects how many rounds must be completed. The sequence RAM is loadable at run time, and button count, depth and timing are parameters. It sits between the debounced button inputs and the LED/7-seg debug wrapper.

---
 rtl/genius_jogo_param_if.sv | 32 +++
 rtl/genius_jogo_param.sv | 226 ++++++++++++++++++++++
 tb/tb_genius_jogo_param.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/genius_jogo_param_if.sv
// Game-side signal bundle for genius_jogo_param: player/load inputs, LED echo,
// end-of-game flags and debug taps. The core takes the slave view.
interface genius_jogo_param_if #(
  parameter int N_BOTOES     = 4,
  parameter int PROFUNDIDADE = 16
);
  localparam int AW = $clog2(PROFUNDIDADE);

  logic                iniciar;
  logic                nivel;
  logic [N_BOTOES-1:0] botoes;
  logic                carrega;
  logic [N_BOTOES-1:0] carrega_dado;
  logic [N_BOTOES-1:0] leds;
  logic                ganhou;
  logic                perdeu;
  logic                timeout;
  logic                pronto;
  logic [3:0]          db_estado;
  logic [AW-1:0]       db_rodada;
  logic [N_BOTOES-1:0] db_jogada;

  modport master (
    output iniciar, nivel, botoes, carrega, carrega_dado,
    input  leds, ganhou, perdeu, timeout, pronto, db_estado, db_rodada, db_jogada
  );

  modport slave (
    input  iniciar, nivel, botoes, carrega, carrega_dado,
    output leds, ganhou, perdeu, timeout, pronto, db_estado, db_rodada, db_jogada
  );
endinterface

// File: rtl/genius_jogo_param.sv
// Parametrised memory-game core: plays back a loadable sequence, checks the player's
// repeats with a per-move timeout. Optional extra-move round via JOGADA_ADICIONAL_EN.
module genius_jogo_param #(
  parameter int N_BOTOES       = 4,
  parameter int PROFUNDIDADE   = 16,
  parameter int TIMEOUT_CICLOS = 5000,
  parameter int MOSTRA_CICLOS  = 1000
) (
  input logic             clock,
  input logic             reset,
  genius_jogo_param_if.slave io
);
  localparam int AW = $clog2(PROFUNDIDADE);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  localparam int CW = $clog2(MOSTRA_CICLOS + 1);
  localparam logic [TW-1:0] T_FIM     = TW'(TIMEOUT_CICLOS - 1);
  localparam logic [CW-1:0] C_FIM     = CW'(MOSTRA_CICLOS - 1);
  localparam logic [AW-1:0] ULT_LONGO = AW'(PROFUNDIDADE - 1);
  localparam logic [AW-1:0] ULT_CURTO = AW'(PROFUNDIDADE / 2 - 1);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    PREPARA     = 4'd1,
    MOSTRA      = 4'd2,
    APAGA       = 4'd3,
    ESPERA      = 4'd4,
    COMPARA     = 4'd5,
    PROX_RODADA = 4'd6,
    ADICIONA    = 4'd7,
    FIM_GANHOU  = 4'd10,
    FIM_PERDEU  = 4'd11,
    FIM_TIMEOUT = 4'd12
  } estado_t;

  estado_t             estado_q, estado_d;
  logic [AW-1:0]       rodada_q, rodada_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [AW-1:0]       ptr_q, ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [N_BOTOES-1:0] prev_q, prev_d;
  logic [N_BOTOES-1:0] jogada_q, jogada_d;
  logic                mv_vld_q, mv_vld_d;

  logic [N_BOTOES-1:0] mem_q [PROFUNDIDADE];
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [N_BOTOES-1:0] mem_wdata;

  logic                livre, aceita, acerto;
  logic [AW-1:0]       ultima;

  // Moves are only latched while a move is expected, so the debug tap and the
  // pending-move pulse stay frozen through playback and the final states.
  always_comb begin
    aceita   = (estado_q == ESPERA) || (estado_q == ADICIONA);
    prev_d   = io.botoes;
    mv_vld_d = aceita && (prev_q == '0) && (io.botoes != '0);
    jogada_d = mv_vld_d ? io.botoes : jogada_q;
    acerto   = $onehot(jogada_q) && (jogada_q == mem_q[addr_q]);
    ultima   = io.nivel ? ULT_LONGO : ULT_CURTO;
    livre    = (estado_q == INICIAL) || (estado_q == FIM_GANHOU) ||
               (estado_q == FIM_PERDEU) || (estado_q == FIM_TIMEOUT);
  end

  always_comb begin
    estado_d  = estado_q;
    rodada_d  = rodada_q;
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timer_d   = timer_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = io.carrega_dado;

    if (livre) begin
      if (io.iniciar) begin
        ptr_d    = '0;
        estado_d = PREPARA;
      end else if (io.carrega) begin
        mem_we = 1'b1;
        ptr_d  = ptr_q + AW'(1);
      end
    end

    case (estado_q)
      PREPARA: begin
        rodada_d = '0;
        addr_d   = '0;
        cnt_d    = '0;
        estado_d = MOSTRA;
      end
      MOSTRA: begin
        if (cnt_q == C_FIM) begin
          cnt_d    = '0;
          estado_d = APAGA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      APAGA: begin
        if (cnt_q == C_FIM) begin
          cnt_d = '0;
          if (addr_q == rodada_q) begin
            addr_d   = '0;
            timer_d  = '0;
            estado_d = ESPERA;
          end else begin
            addr_d   = addr_q + AW'(1);
            estado_d = MOSTRA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      // A move landing on the terminal timer count still wins over the timeout.
      ESPERA: begin
        if (mv_vld_q) begin
          timer_d  = '0;
          estado_d = COMPARA;
        end else if (timer_q == T_FIM) begin
          estado_d = FIM_TIMEOUT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      COMPARA: begin
        if (!acerto) begin
          estado_d = FIM_PERDEU;
        end else if (addr_q != rodada_q) begin
          addr_d   = addr_q + AW'(1);
          timer_d  = '0;
          estado_d = ESPERA;
        end else begin
`ifdef JOGADA_ADICIONAL_EN
          if (rodada_q == ultima) begin
            estado_d = PROX_RODADA;
          end else begin
            timer_d  = '0;
            estado_d = ADICIONA;
          end
`else
          estado_d = PROX_RODADA;
`endif
        end
      end
      PROX_RODADA: begin
        if (rodada_q == ultima) begin
          estado_d = FIM_GANHOU;
        end else begin
          rodada_d = rodada_q + AW'(1);
          addr_d   = '0;
          cnt_d    = '0;
          estado_d = MOSTRA;
        end
      end
`ifdef JOGADA_ADICIONAL_EN
      // The extra move extends the stored sequence; it is first shown next round.
      ADICIONA: begin
        if (mv_vld_q) begin
          if ($onehot(jogada_q)) begin
            mem_we    = 1'b1;
            mem_waddr = rodada_q + AW'(1);
            mem_wdata = jogada_q;
            estado_d  = PROX_RODADA;
          end else begin
            estado_d = FIM_PERDEU;
          end
        end else if (timer_q == T_FIM) begin
          estado_d = FIM_TIMEOUT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
`endif
      INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: ;
      default: estado_d = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= INICIAL;
      rodada_q <= '0;
      addr_q   <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
      timer_q  <= '0;
      prev_q   <= '0;
      jogada_q <= '0;
      mv_vld_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      rodada_q <= rodada_d;
      addr_q   <= addr_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      timer_q  <= timer_d;
      prev_q   <= prev_d;
      jogada_q <= jogada_d;
      mv_vld_q <= mv_vld_d;
    end
  end

  // Sequence storage has no reset; contents are whatever was last loaded.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    io.leds = '0;
    case (estado_q)
      MOSTRA:                    io.leds = mem_q[addr_q];
      ESPERA, COMPARA, ADICIONA: io.leds = io.botoes;
      default:                   io.leds = '0;
    endcase
    io.ganhou    = (estado_q == FIM_GANHOU);
    io.perdeu    = (estado_q == FIM_PERDEU) || (estado_q == FIM_TIMEOUT);
    io.timeout   = (estado_q == FIM_TIMEOUT);
    io.pronto    = (estado_q == FIM_GANHOU) || io.perdeu;
    io.db_estado = estado_q;
    io.db_rodada = rodada_q;
    io.db_jogada = jogada_q;
  end
endmodule

// File: tb/tb_genius_jogo_param.sv
// Scoreboard bench for genius_jogo_param: a game-level model pushes expected playback
// elements and end-of-game results; two monitors pop and compare as the DUT presents them.
module tb_genius_jogo_param;
  localparam int NB = 4;
  localparam int PF = 8;
  localparam int TO = 50;
  localparam int MC = 4;

  typedef struct packed {
    logic       g;
    logic       p;
    logic       t;
    logic [3:0] e;
    logic [2:0] r;
    logic [3:0] j;
  } fim_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  genius_jogo_param_if #(.N_BOTOES(NB), .PROFUNDIDADE(PF)) io ();

  genius_jogo_param #(
    .N_BOTOES(NB), .PROFUNDIDADE(PF), .TIMEOUT_CICLOS(TO), .MOSTRA_CICLOS(MC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io(io.slave)
  );

  int errors = 0;
  int checks = 0;

  logic [3:0] ref_mem [PF];
  int         ref_ptr = 0;
  logic [3:0] ultima  = '0;
  logic [3:0] exp_leds[$];
  fim_t       exp_fim[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic abortar(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: DUT did not progress within cycle budget", nm);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  function automatic fim_t mk(input logic g, p, t, input int e, r, input logic [3:0] j);
    fim_t f;
    f.g = g; f.p = p; f.t = t;
    f.e = 4'(e); f.r = 3'(r); f.j = j;
    return f;
  endfunction

  function automatic logic [3:0] unico();
    logic [3:0] v;
    v = 4'b0001 << $urandom_range(0, 3);
    return v;
  endfunction

  function automatic logic [3:0] errado(input logic [3:0] x);
    logic [3:0] w;
    w = unico();
    while (w == x) w = unico();
    return w;
  endfunction

  function automatic logic [3:0] nao_unico();
    logic [3:0] w;
    w = 4'($urandom_range(1, 15));
    while ($onehot(w)) w = 4'($urandom_range(1, 15));
    return w;
  endfunction

  task automatic wait_estado(input logic [3:0] s);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (io.db_estado == s) return;
    end
    abortar("wait_estado");
  endtask

  task automatic espera_pronto();
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (io.pronto) return;
    end
    abortar("espera_pronto");
  endtask

  // One-cycle press, then wait until the core has left the state it was in.
  task automatic apertar(input logic [3:0] v);
    logic [3:0] s;
    s = io.db_estado;
    io.botoes = v;
    @(negedge clock);
    io.botoes = '0;
    for (int i = 0; i < 10; i++) begin
      if (io.db_estado != s) return;
      @(negedge clock);
    end
    abortar("apertar");
  endtask

  // Delay 48 is the last cycle where a press still beats the 50-cycle timeout.
  task automatic atraso();
    int d;
    d = ($urandom_range(0, 3) == 0) ? TO - 2 : int'($urandom_range(0, 5));
    repeat (d) @(negedge clock);
  endtask

  task automatic carregar(input logic [3:0] v);
    io.carrega = 1'b1;
    io.carrega_dado = v;
    @(negedge clock);
    io.carrega = 1'b0;
    ref_mem[ref_ptr] = v;
    ref_ptr = (ref_ptr + 1) % PF;
  endtask

  task automatic carregar_base();
    logic [3:0] seq [PF];
    seq = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd4, 4'd2, 4'd1, 4'd2};
    for (int i = 0; i < PF; i++) carregar(seq[i]);
  endtask

  task automatic iniciar();
    exp_leds.push_back(ref_mem[0]);
    io.iniciar = 1'b1;
    @(negedge clock);
    io.iniciar = 1'b0;
    ref_ptr = 0;
  endtask

  // tipo: 0 clean game, 1 wrong one-hot, 2 non-one-hot, 3 ESPERA timeout, 4 ADICIONA timeout
  task automatic jogo(input logic nv, input int frod, input int fadr, input int tipo,
                      input logic [3:0] vf);
    int ult;
    logic [3:0] v;
    ult = nv ? PF - 1 : PF / 2 - 1;
    io.nivel = nv;
    iniciar();
    for (int r = 0; r <= ult; r++) begin
      for (int a = 0; a <= r; a++) begin
        wait_estado(4'd4);
        if (r == frod && a == fadr && (tipo == 1 || tipo == 2 || tipo == 3)) begin
          if (tipo == 3) begin
            exp_fim.push_back(mk(1'b0, 1'b1, 1'b1, 12, r, ultima));
            espera_pronto();
            return;
          end
          if (tipo == 1) v = (vf != '0 && vf != ref_mem[a]) ? vf : errado(ref_mem[a]);
          else           v = (vf != '0) ? vf : nao_unico();
          exp_fim.push_back(mk(1'b0, 1'b1, 1'b0, 11, r, v));
          atraso();
          apertar(v);
          ultima = v;
          espera_pronto();
          return;
        end
        v = ref_mem[a];
        if (r == ult && a == r) exp_fim.push_back(mk(1'b1, 1'b0, 1'b0, 10, r, v));
        atraso();
        apertar(v);
        ultima = v;
      end
      if (r == ult) begin
        espera_pronto();
        return;
      end
`ifdef JOGADA_ADICIONAL_EN
      wait_estado(4'd7);
      if (r == frod && tipo == 4) begin
        exp_fim.push_back(mk(1'b0, 1'b1, 1'b1, 12, r, ultima));
        espera_pronto();
        return;
      end
      v = unico();
      atraso();
      apertar(v);
      ref_mem[r+1] = v;
      ultima = v;
`endif
      for (int a = 0; a <= r + 1; a++) exp_leds.push_back(ref_mem[a]);
      // Restart and load attempts mid-game must have no effect.
      if (r == 0) begin
        io.iniciar = 1'b1;
        io.carrega = 1'b1;
        io.carrega_dado = 4'hF;
        @(negedge clock);
        io.iniciar = 1'b0;
        io.carrega = 1'b0;
      end
    end
  endtask

  // Playback monitor: every entry into MOSTRA presents one sequence element.
  initial begin
    logic [3:0] ant;
    logic [3:0] e;
    ant = '0;
    forever begin
      @(negedge clock);
      if (io.db_estado == 4'd2 && ant != 4'd2) begin
        if (exp_leds.size() == 0) begin
          chk("leds_inesperado", {28'd0, io.leds}, 32'hFFFF_FFFF);
        end else begin
          e = exp_leds.pop_front();
          chk("leds_playback", {28'd0, io.leds}, {28'd0, e});
        end
      end
      ant = io.db_estado;
    end
  end

  // Result monitor: rising pronto presents the end-of-game flags.
  initial begin
    logic ant;
    fim_t f;
    ant = 1'b0;
    forever begin
      @(negedge clock);
      if (io.pronto && !ant) begin
        if (exp_fim.size() == 0) begin
          chk("fim_inesperado", 32'd1, 32'd0);
        end else begin
          f = exp_fim.pop_front();
          chk("ganhou",    {31'd0, io.ganhou},    {31'd0, f.g});
          chk("perdeu",    {31'd0, io.perdeu},    {31'd0, f.p});
          chk("timeout",   {31'd0, io.timeout},   {31'd0, f.t});
          chk("db_estado", {28'd0, io.db_estado}, {28'd0, f.e});
          chk("db_rodada", {29'd0, io.db_rodada}, {29'd0, f.r});
          chk("db_jogada", {28'd0, io.db_jogada}, {28'd0, f.j});
        end
      end
      ant = io.pronto;
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_leds"},    {28'd0, io.leds},      32'd0);
    chk({nm, "_ganhou"},  {31'd0, io.ganhou},    32'd0);
    chk({nm, "_perdeu"},  {31'd0, io.perdeu},    32'd0);
    chk({nm, "_timeout"}, {31'd0, io.timeout},   32'd0);
    chk({nm, "_pronto"},  {31'd0, io.pronto},    32'd0);
    chk({nm, "_estado"},  {28'd0, io.db_estado}, 32'd0);
    chk({nm, "_rodada"},  {29'd0, io.db_rodada}, 32'd0);
    chk({nm, "_jogada"},  {28'd0, io.db_jogada}, 32'd0);
  endtask

  initial begin
    int ult;
    int n;
    io.iniciar = 1'b0;
    io.nivel = 1'b0;
    io.botoes = '0;
    io.carrega = 1'b0;
    io.carrega_dado = '0;
    #1;
    chk_zero("reset");
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    carregar_base();
    jogo(1'b1, -1, 0, 0, 4'd0);
    @(negedge clock);
    jogo(1'b0, -1, 0, 0, 4'd0);
    @(negedge clock);
    carregar_base();
    jogo(1'b1, 2, 2, 1, 4'd8);
    @(negedge clock);
    carregar_base();
    jogo(1'b1, 1, 0, 3, 4'd0);
    @(negedge clock);
    jogo(1'b1, int'($urandom_range(0, 3)), 0, 2, 4'b0011);
`ifdef JOGADA_ADICIONAL_EN
    @(negedge clock);
    jogo(1'b1, 0, 0, 4, 4'd0);
`endif

    for (int g = 0; g < 5; g++) begin
      logic nv;
      int fr;
      @(negedge clock);
      n = PF + int'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) carregar(unico());
      nv = 1'($urandom_range(0, 1));
      ult = nv ? PF - 1 : PF / 2 - 1;
      fr = int'($urandom_range(0, ult));
      jogo(nv, fr, int'($urandom_range(0, fr)), int'($urandom_range(0, 3)), 4'd0);
    end

    // Asynchronous reset in the middle of playback.
    @(negedge clock);
    carregar_base();
    io.nivel = 1'b1;
    iniciar();
    wait_estado(4'd2);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_zero("reset_mostra");
    @(negedge clock);
    reset = 1'b1;
    ref_ptr = 0;
    ultima = '0;
    @(negedge clock);
    carregar_base();
    jogo(1'b0, -1, 0, 0, 4'd0);

    repeat (5) @(negedge clock);
    chk("fila_leds_pendente", exp_leds.size(), 32'd0);
    chk("fila_fim_pendente", exp_fim.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
